// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter: shares one L2 among NUM_CORES L1 miss requesters.
// Round-robin grant, one outstanding L2 lookup at a time. The L2 handshake
// is find_start -> (updated | timeout). At most one L2 back-invalidation is
// broadcast per transaction.
module l2_request_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int WAY_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 20
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CORES-1:0]             req_valid,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  req_addr,
  output logic [NUM_CORES-1:0]             resp_valid,
  output logic                             resp_hit,
  output logic [WAY_WIDTH:0]               resp_hit_way,
  output logic                             resp_error,
  output logic                             l2_find_start,
  output logic [ADDR_WIDTH-1:0]            l2_addr,
  input  logic                             l2_found,
  input  logic [WAY_WIDTH:0]               l2_hit_way,
  input  logic                             l2_updated,
  input  logic                             l2_back_inv,
  input  logic [ADDR_WIDTH-1:0]            l2_back_inv_data,
  output logic                             binv_valid,
  output logic [ADDR_WIDTH-1:0]            binv_addr,
  output logic                             busy,
  output logic [CNT_WIDTH-1:0]             req_count,
  output logic [CNT_WIDTH-1:0]             hit_count
);

  localparam int IDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCW-1:0]     WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);
  localparam logic [WAY_WIDTH:0] MISS_WAY  = {1'b1, {WAY_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                                state, state_nxt;
  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0]  core_addr;
  logic [IDW-1:0]                        rr_ptr, grant_id, gnt_id, cand;
  logic                                  gnt_found;
  logic [WCW-1:0]                        wait_cnt;
  logic                                  binv_taken;

  assign core_addr = req_addr;

  // Round-robin scan starting at rr_ptr; NUM_CORES is a power of two so the
  // index wraps naturally in IDW bits.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = rr_ptr + IDW'(i);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a same-cycle l2_updated wins over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (gnt_found) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (l2_updated || wait_cnt == WAIT_LAST) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs: start pulse, response strobe, busy.
  always_comb begin
    l2_find_start = (state == S_ISSUE);
    busy          = (state != S_IDLE);
    resp_valid    = '0;
    if (state == S_RESP) resp_valid[grant_id] = 1'b1;
  end

  // Datapath: grant latch, wait counter, capture of L2 result, back-inv, stats.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id     <= '0;
      rr_ptr       <= '0;
      l2_addr      <= '0;
      wait_cnt     <= '0;
      binv_taken   <= 1'b0;
      binv_valid   <= 1'b0;
      binv_addr    <= '0;
      resp_hit     <= 1'b0;
      resp_hit_way <= '0;
      resp_error   <= 1'b0;
      req_count    <= '0;
      hit_count    <= '0;
    end else begin
      binv_valid <= 1'b0;
      case (state)
        S_IDLE: if (gnt_found) begin
          grant_id <= gnt_id;
          l2_addr  <= core_addr[gnt_id];
        end
        S_ISSUE: begin
          wait_cnt   <= '0;
          binv_taken <= 1'b0;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (l2_back_inv && !binv_taken) begin
            binv_valid <= 1'b1;
            binv_addr  <= l2_back_inv_data;
            binv_taken <= 1'b1;
          end
          // resp_* double as the capture registers and hold between responses.
          if (l2_updated) begin
            resp_hit     <= l2_found;
            resp_hit_way <= l2_hit_way;
            resp_error   <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            resp_hit     <= 1'b0;
            resp_hit_way <= MISS_WAY;
            resp_error   <= 1'b1;
          end
        end
        S_RESP: begin
          rr_ptr <= grant_id + 1'b1;
          if (~&req_count)             req_count <= req_count + 1'b1;
          if (resp_hit && ~&hit_count) hit_count <= hit_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter with a small behavioural L2 responder.
module tb_l2_request_arbiter;
  localparam int NC = 4, AW = 32, WW = 4, TO = 16, CW = 20;

  logic               clk = 1'b0, reset = 1'b1;
  logic [NC-1:0]      req_valid = '0;
  logic [NC*AW-1:0]   req_addr = '0;
  logic [NC-1:0]      resp_valid;
  logic               resp_hit, resp_error, l2_find_start, binv_valid, busy;
  logic [WW:0]        resp_hit_way;
  logic [AW-1:0]      l2_addr, binv_addr;
  logic               l2_found = 1'b0, l2_updated = 1'b0, l2_back_inv = 1'b0;
  logic [WW:0]        l2_hit_way = '0;
  logic [AW-1:0]      l2_back_inv_data = '0;
  logic [CW-1:0]      req_count, hit_count;

  l2_request_arbiter #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .WAY_WIDTH(WW),
                       .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_hit_way(resp_hit_way),
    .resp_error(resp_error), .l2_find_start(l2_find_start), .l2_addr(l2_addr),
    .l2_found(l2_found), .l2_hit_way(l2_hit_way), .l2_updated(l2_updated),
    .l2_back_inv(l2_back_inv), .l2_back_inv_data(l2_back_inv_data),
    .binv_valid(binv_valid), .binv_addr(binv_addr), .busy(busy),
    .req_count(req_count), .hit_count(hit_count));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // L2 model knobs (0 = never) and observation state.
  int          m_delay = 5, m_binv_at = 0, m_cnt = 0;
  logic        m_active = 1'b0, m_found = 1'b0;
  logic [WW:0] m_way = 5'd16;
  logic [AW-1:0] m_binv_data = '0;
  int          fs_count = 0, fs_cyc = 0, binv_count = 0, binv_on_fs = 0;
  int          upd_cyc = 0, min_gap = 1000;
  logic        upd_seen = 1'b0;
  logic [AW-1:0] fs_addr = '0, binv_last = '0;

  // L2 responder and event monitor, sampled/driven on the falling edge.
  always @(negedge clk) begin
    l2_updated  = 1'b0;
    l2_back_inv = 1'b0;
    if (reset) begin
      m_active = 1'b0;
      upd_seen = 1'b0;
    end else begin
      if (binv_valid) begin
        binv_count++;
        binv_last = binv_addr;
        if (l2_find_start) binv_on_fs++;
      end
      if (l2_find_start) begin
        fs_count++;
        fs_cyc  = cyc;
        fs_addr = l2_addr;
        if (upd_seen && (cyc - upd_cyc) < min_gap) min_gap = cyc - upd_cyc;
        m_active = 1'b1;
        m_cnt    = 0;
      end else if (m_active) begin
        m_cnt++;
        if (m_binv_at > 0 && m_cnt >= m_binv_at && m_cnt < m_binv_at + 2) begin
          l2_back_inv      = 1'b1;
          l2_back_inv_data = m_binv_data;
        end
        if (m_delay > 0 && m_cnt == m_delay) begin
          l2_updated = 1'b1;
          l2_found   = m_found;
          l2_hit_way = m_way;
          m_active   = 1'b0;
          upd_cyc    = cyc;
          upd_seen   = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [NC-1:0] r_vec;
  logic          r_hit, r_err;
  logic [WW:0]   r_way;
  logic [AW-1:0] r_addr;
  int            r_cyc;

  // Wait (bounded) for one response; the responding core then drops its request.
  task automatic wait_resp(input string tag);
    logic got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        got    = 1'b1;
        r_vec  = resp_valid;
        r_hit  = resp_hit;
        r_way  = resp_hit_way;
        r_err  = resp_error;
        r_addr = l2_addr;
        r_cyc  = cyc;
        req_valid = req_valid & ~resp_valid;
      end
    end
    check({tag, "_seen"}, 64'(got), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  int  fs0, b0;
  logic seen_resp;

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_find_start", 64'(l2_find_start), 64'd0);
    check("rst_counts", 64'({req_count, hit_count}), 64'd0);
    check("rst_binv_addr", 64'({binv_valid, l2_addr}), 64'd0);
    reset = 1'b0;

    // 1: single miss from core 0.
    @(negedge clk);
    req_addr[0*AW +: AW] = 32'h0000_1230;
    req_valid = 4'b0001;
    wait_resp("t1");
    check("t1_vec", 64'(r_vec), 64'b0001);
    check("t1_hit", 64'(r_hit), 64'd0);
    check("t1_way", 64'(r_way), 64'd16);
    check("t1_err", 64'(r_err), 64'd0);
    @(negedge clk); #1;
    check("t1_addr", 64'(fs_addr), 64'h1230);
    check("t1_fs_count", 64'(fs_count), 64'd1);
    check("t1_req_count", 64'(req_count), 64'd1);
    check("t1_hit_count", 64'(hit_count), 64'd0);

    // 2: all cores at once from reset, served 0,1,2,3.
    do_reset();
    for (int i = 0; i < NC; i++) req_addr[i*AW +: AW] = 32'h1000_0000 + 32'(i * 'h40);
    req_valid = 4'b1111;
    #1; fs0 = fs_count; min_gap = 1000;
    for (int i = 0; i < NC; i++) begin
      wait_resp("t2");
      check("t2_order", 64'(r_vec), 64'(4'b0001 << i));
      check("t2_addr_stable", 64'(r_addr), 64'(32'h1000_0000 + 32'(i * 'h40)));
    end
    @(negedge clk); #1;
    check("t2_fs_count", 64'(fs_count - fs0), 64'd4);
    check("t2_gap_ge3", 64'(min_gap >= 3), 64'd1);
    check("t2_req_count", 64'(req_count), 64'd4);
    // rr_ptr back at 0: with cores 1 and 3 pending, core 1 goes first.
    req_valid = 4'b1010;
    wait_resp("t2rr");
    check("t2_rr_first", 64'(r_vec), 64'b0010);
    wait_resp("t2rr");
    check("t2_rr_second", 64'(r_vec), 64'b1000);

    // 3: core 2 hit in way 2.
    @(negedge clk);
    m_found = 1'b1; m_way = 5'd2; m_delay = 3;
    req_valid = 4'b0100;
    wait_resp("t3");
    check("t3_vec", 64'(r_vec), 64'b0100);
    check("t3_hit", 64'(r_hit), 64'd1);
    check("t3_way", 64'(r_way), 64'd2);
    @(negedge clk); #1;
    check("t3_hit_count", 64'(hit_count), 64'd1);
    check("t3_req_count", 64'(req_count), 64'd7);

    // 4: back-invalidation held two cycles during WAIT; core 0 drops its request.
    m_found = 1'b0; m_way = 5'd16; m_delay = 6; m_binv_at = 2;
    m_binv_data = 32'hABCD_0040;
    b0 = binv_count; fs0 = fs_count;
    req_valid = 4'b0001;
    for (int i = 0; i < 20 && fs_count == fs0; i++) @(negedge clk);
    #1; req_valid = 4'b0000;
    wait_resp("t4");
    check("t4_vec", 64'(r_vec), 64'b0001);
    check("t4_err", 64'(r_err), 64'd0);
    @(negedge clk); #1;
    check("t4_binv_once", 64'(binv_count - b0), 64'd1);
    check("t4_binv_addr", 64'(binv_last), 64'hABCD_0040);
    check("t4_binv_not_issue", 64'(binv_on_fs), 64'd0);

    // 5: L2 never answers -> timeout error 17 cycles after find_start.
    m_delay = 0; m_binv_at = 0;
    req_valid = 4'b1000;
    wait_resp("t5");
    check("t5_vec", 64'(r_vec), 64'b1000);
    check("t5_latency", 64'(r_cyc - fs_cyc), 64'd17);
    check("t5_err", 64'(r_err), 64'd1);
    check("t5_hit", 64'(r_hit), 64'd0);
    check("t5_way", 64'(r_way), 64'd16);
    @(negedge clk); #1;
    check("t5_idle", 64'(busy), 64'd0);
    check("t5_req_count", 64'(req_count), 64'd9);

    // 6: reset while core 1 is in WAIT; re-grant after reset.
    req_addr[1*AW +: AW] = 32'h0000_5550;
    req_valid = 4'b0010;
    fs0 = fs_count;
    for (int i = 0; i < 20 && fs_count == fs0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    seen_resp = 1'b0;
    reset = 1'b1;
    m_delay = 4;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid != '0) seen_resp = 1'b1;
    end
    check("t6_counts", 64'({req_count, hit_count}), 64'd0);
    check("t6_busy_rst", 64'(busy), 64'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    if (resp_valid != '0) seen_resp = 1'b1;
    check("t6_cyc1_no_start", 64'(l2_find_start), 64'd0);
    @(negedge clk);
    check("t6_cyc2_start", 64'(l2_find_start), 64'd1);
    check("t6_addr", 64'(l2_addr), 64'h5550);
    check("t6_no_resp", 64'(seen_resp), 64'd0);
    wait_resp("t6");
    check("t6_vec", 64'(r_vec), 64'b0010);
    @(negedge clk); #1;
    check("t6_req_count", 64'(req_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
